// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/PC-enable sequencing and run/halt state for the five-stage pipeline.
// Optional perf counters (cyc_cnt, stall_cnt, flush_cnt) are built when PIPECTRL_PERF_EN is defined.
module pipeline_hazard_ctrl (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       exmem_dREN,
  input  logic       exmem_dWEN,
  input  logic       exmem_halt,
  input  logic       idex_dREN,
  input  logic [4:0] idex_wsel,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_rs_used,
  input  logic       ifid_rt_used,
  input  logic       br_taken,
  output logic       pc_EN,
  output logic       ifid_EN,
  output logic       ifid_flush,
  output logic       idex_EN,
  output logic       idex_flush,
  output logic       exmem_EN,
  output logic       exmem_flush,
  output logic       memwb_EN,
  output logic       memwb_flush,
  output logic       iREN,
`ifdef PIPECTRL_PERF_EN
  output logic [31:0] cyc_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic       halt
);
  typedef enum logic {RUN, HALT} state_t;
  state_t r_state, w_next;
  logic   r_halt;
  logic   w_run, w_dwait, w_luse, w_stall_rule, w_br_rule;
  assign w_run   = (r_state == RUN);
  assign w_dwait = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign w_luse  = idex_dREN & (idex_wsel != 5'd0) &
                   ((ifid_rs_used & (ifid_rs == idex_wsel)) | (ifid_rt_used & (ifid_rt == idex_wsel)));
  assign w_br_rule    = w_run & ~w_dwait & ~exmem_halt & br_taken;
  assign w_stall_rule = w_run & (w_dwait | (~exmem_halt & ~br_taken & (w_luse | ~ihit)));
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_halt  <= (w_next == HALT);
    end
  end
  assign halt = r_halt;
  always_comb begin
    w_next      = r_state;
    pc_EN       = 1'b0;
    ifid_EN     = 1'b0;
    ifid_flush  = 1'b0;
    idex_EN     = 1'b0;
    idex_flush  = 1'b0;
    exmem_EN    = 1'b0;
    exmem_flush = 1'b0;
    memwb_EN    = 1'b0;
    memwb_flush = 1'b0;
    iREN        = w_run & ~w_dwait;
    if (w_run) begin
      // Priority order matters: a pending data access freezes everything, even a halt in MEM.
      if (w_dwait) begin
        memwb_flush = 1'b1;
      end else if (exmem_halt) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_EN    = 1'b1;
        w_next      = HALT;
      end else if (br_taken) begin
        pc_EN      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_EN   = 1'b1;
        memwb_EN   = 1'b1;
      end else if (w_luse || !ihit) begin
        idex_flush = 1'b1;
        exmem_EN   = 1'b1;
        memwb_EN   = 1'b1;
      end else begin
        pc_EN    = 1'b1;
        ifid_EN  = 1'b1;
        idex_EN  = 1'b1;
        exmem_EN = 1'b1;
        memwb_EN = 1'b1;
      end
    end
  end
`ifdef PIPECTRL_PERF_EN
  logic [31:0] r_cyc_cnt, r_stall_cnt, r_flush_cnt;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cyc_cnt   <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_cyc_cnt   <= r_cyc_cnt + {31'd0, w_run};
      r_stall_cnt <= r_stall_cnt + {31'd0, w_stall_rule};
      r_flush_cnt <= r_flush_cnt + {31'd0, w_br_rule};
    end
  end
  assign cyc_cnt   = r_cyc_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused = w_stall_rule ^ w_br_rule;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus randomized checks against a rule-table reference model.
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, idex_dREN, ifid_rs_used, ifid_rt_used, br_taken;
  logic [4:0] idex_wsel, ifid_rs, ifid_rt;
  logic pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush, exmem_EN, exmem_flush, memwb_EN, memwb_flush, iREN, halt;
`ifdef PIPECTRL_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
  int m_cyc, m_stall, m_flush;
`endif
  int checks = 0, failures = 0;
  bit m_halted = 0;
  always #5 CLK = ~CLK;
  pipeline_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .exmem_halt(exmem_halt), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used), .br_taken(br_taken),
    .pc_EN(pc_EN), .ifid_EN(ifid_EN), .ifid_flush(ifid_flush), .idex_EN(idex_EN), .idex_flush(idex_flush),
    .exmem_EN(exmem_EN), .exmem_flush(exmem_flush), .memwb_EN(memwb_EN), .memwb_flush(memwb_flush),
    .iREN(iREN),
`ifdef PIPECTRL_PERF_EN
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .halt(halt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  typedef enum int {R_DWAIT, R_HALT, R_BR, R_STALL, R_RUN} rule_t;
  function automatic rule_t rule();
    bit dw, lu;
    dw = (exmem_dREN || exmem_dWEN) && !dhit;
    lu = idex_dREN && idex_wsel != 0 &&
         ((ifid_rs_used && ifid_rs == idex_wsel) || (ifid_rt_used && ifid_rt == idex_wsel));
    if (dw) return R_DWAIT;
    if (exmem_halt) return R_HALT;
    if (br_taken) return R_BR;
    if (lu || !ihit) return R_STALL;
    return R_RUN;
  endfunction
  // {pc, ifidE, ifidF, idexE, idexF, exmemE, exmemF, memwbE, memwbF, iREN}
  function automatic logic [9:0] exp_ctrl();
    if (m_halted) return 10'b0;
    case (rule())
      R_DWAIT: return 10'b0000000010;
      R_HALT:  return 10'b0010101101;
      R_BR:    return 10'b1010110101;
      R_STALL: return 10'b0000110101;
      default: return 10'b1101010101;
    endcase
  endfunction
  function automatic logic [9:0] dut_ctrl();
    return {pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush, exmem_EN, exmem_flush, memwb_EN, memwb_flush, iREN};
  endfunction
  task automatic check_outputs(input string tag);
    chk({tag, "_ctrl"}, {22'd0, dut_ctrl()}, {22'd0, exp_ctrl()});
    chk({tag, "_halt"}, {31'd0, halt}, {31'd0, m_halted});
`ifdef PIPECTRL_PERF_EN
    chk({tag, "_cyc"}, cyc_cnt, m_cyc);
    chk({tag, "_stall"}, stall_cnt, m_stall);
    chk({tag, "_flush"}, flush_cnt, m_flush);
`endif
  endtask
  task automatic step(input string tag);
    rule_t r;
    #1 check_outputs(tag);
    r = rule();
    @(posedge CLK);
    if (nRST && !m_halted) begin
`ifdef PIPECTRL_PERF_EN
      m_cyc++;
      if (r == R_DWAIT || r == R_STALL) m_stall++;
      if (r == R_BR) m_flush++;
`endif
      if (r == R_HALT) m_halted = 1;
    end
    @(negedge CLK);
  endtask
  task automatic idle();
    ihit = 1; dhit = 0; exmem_dREN = 0; exmem_dWEN = 0; exmem_halt = 0; idex_dREN = 0;
    idex_wsel = 0; ifid_rs = 0; ifid_rt = 0; ifid_rs_used = 0; ifid_rt_used = 0; br_taken = 0;
  endtask
  task automatic do_reset();
    nRST = 0;
    m_halted = 0;
`ifdef PIPECTRL_PERF_EN
    m_cyc = 0; m_stall = 0; m_flush = 0;
`endif
    #1 check_outputs("rst");
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask
  initial begin
    idle();
    @(negedge CLK);
    do_reset();
    step("run");
    exmem_dREN = 1;
    repeat (3) step("dwait");
    dhit = 1; step("dhit");
    idle(); idex_dREN = 1; idex_wsel = 8; ifid_rs = 8; ifid_rs_used = 1;
    step("luse");
    idex_wsel = 0; ifid_rs = 0; step("wsel0");
    idex_wsel = 9; ifid_rt = 9; ifid_rt_used = 1; step("luse_rt");
    ifid_rt_used = 0; step("rt_unused");
    ifid_rt_used = 1; br_taken = 1; step("br_luse");
    idle(); ihit = 0; step("noihit");
    idle(); exmem_halt = 1; exmem_dWEN = 1; dhit = 0;
    repeat (2) step("halt_dwait");
    dhit = 1; step("halt_go");
    idle(); br_taken = 1;
    repeat (10) step("halted");
    idle(); exmem_dREN = 1; step("pre_rst");
    @(posedge CLK); #2 do_reset();
    idle(); step("after_rst");
    for (int i = 0; i < 2000; i++) begin
      ihit = ($urandom % 8) != 0;
      dhit = $urandom % 2;
      exmem_dREN = ($urandom % 4) == 0;
      exmem_dWEN = ($urandom % 6) == 0;
      exmem_halt = ($urandom % 40) == 0;
      idex_dREN = ($urandom % 3) == 0;
      idex_wsel = 5'($urandom % 4);
      ifid_rs = 5'($urandom % 4);
      ifid_rt = 5'($urandom % 4);
      ifid_rs_used = $urandom % 2;
      ifid_rt_used = $urandom % 2;
      br_taken = ($urandom % 6) == 0;
      if (m_halted && ($urandom % 6) == 0) do_reset();
      else step("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
